obi_ram_data_bridge: RTL and testbench

//  Bridges the core OBI data port (req/gnt/rvalid) onto port B of the example-tb dual-port RAM.

---
 rtl/obi_ram_bridge_pkg.sv | 17 +
 rtl/obi_ram_stall_lfsr.sv | 25 ++
 rtl/obi_ram_data_bridge.sv | 144 ++++++++++++++
 tb/tb_obi_ram_data_bridge.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_ram_bridge_pkg.sv
// Shared types and constants for the OBI-to-RAM data bridge and its stall generator.
package obi_ram_bridge_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam int          STALL_CNT_W = 8;

  function automatic logic [15:0] lfsr_next(input logic [15:0] value);
    return {value[14:0], ^(value & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/obi_ram_stall_lfsr.sv
// Free-running 16-bit LFSR producing a pseudo-random grant stall length in 0..GNT_STALL_MAX.
module obi_ram_stall_lfsr
  import obi_ram_bridge_pkg::*;
#(
  parameter int          GNT_STALL_MAX = 0,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic [STALL_CNT_W-1:0] stall_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign stall_o = STALL_CNT_W'(32'(lfsr_q[7:0]) % 32'(GNT_STALL_MAX + 1));

endmodule

// File: rtl/obi_ram_data_bridge.sv
// OBI data-port to dual-port RAM port-B bridge with optional random grant stalls,
// fixed one-cycle response latency, range checking and transaction counters.
module obi_ram_data_bridge
  import obi_ram_bridge_pkg::*;
#(
  parameter int          ADDR_WIDTH    = 22,
  parameter int          GNT_STALL_MAX = 0,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  stall_en_i,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  data_err_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i,
  output logic [31:0]           rd_count_o,
  output logic [31:0]           wr_count_o
);

  state_e                 state_q, state_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0] stall_s;
  logic                   gnt;
  logic                   in_range;
  logic                   stall_needed;
  logic                   rvalid_q, err_q, we_q;
  logic [31:0]            rd_count_q, wr_count_q;

  obi_ram_stall_lfsr #(
    .GNT_STALL_MAX(GNT_STALL_MAX),
    .LFSR_SEED    (LFSR_SEED)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .stall_o(stall_s)
  );

  generate
    if (ADDR_WIDTH >= 32) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_range_check
      assign in_range = (data_addr_i[31:ADDR_WIDTH] == '0);
    end
  endgenerate

  assign stall_needed = stall_en_i && (GNT_STALL_MAX != 0) && (stall_s != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A stall of s cycles loads cnt=s; the grant fires on the cycle the count reads 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_req_i) begin
          if (!stall_needed) begin
            gnt = 1'b1;
          end else begin
            cnt_d   = stall_s;
            state_d = STALL;
          end
        end
      end
      STALL: begin
        if (!data_req_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == STALL_CNT_W'(1)) begin
          gnt     = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - STALL_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_gnt_o  = gnt;
  assign ram_en_o    = gnt && in_range;
  assign ram_addr_o  = data_addr_i[ADDR_WIDTH-1:0];
  assign ram_we_o    = data_we_i;
  assign ram_be_o    = data_be_i;
  assign ram_wdata_o = data_wdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      rvalid_q <= gnt;
      err_q    <= gnt && !in_range;
      we_q     <= data_we_i;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = err_q;
  assign data_rdata_o  = (rvalid_q && !we_q && !err_q) ? ram_rdata_i : 32'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (rvalid_q && !err_q) begin
      if (we_q) begin
        if (wr_count_q != 32'hFFFF_FFFF) wr_count_q <= wr_count_q + 32'd1;
      end else begin
        if (rd_count_q != 32'hFFFF_FFFF) rd_count_q <= rd_count_q + 32'd1;
      end
    end
  end

  assign rd_count_o = rd_count_q;
  assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_obi_ram_data_bridge.sv
// Scoreboard bench for obi_ram_data_bridge: random OBI traffic against a word-array memory model.
module tb_obi_ram_data_bridge;

  localparam int AW        = 16;
  localparam int STALL_MAX = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_en = 1'b0;
  logic        req = 1'b0;
  logic        gnt;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        ram_en;
  logic [AW-1:0] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [31:0] rd_count, wr_count;

  obi_ram_data_bridge #(
    .ADDR_WIDTH   (AW),
    .GNT_STALL_MAX(STALL_MAX)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .stall_en_i   (stall_en),
    .data_req_i   (req),
    .data_gnt_o   (gnt),
    .data_addr_i  (addr),
    .data_we_i    (we),
    .data_be_i    (be),
    .data_wdata_i (wdata),
    .data_rvalid_o(rvalid),
    .data_rdata_o (rdata),
    .data_err_o   (err),
    .ram_en_o     (ram_en),
    .ram_addr_o   (ram_addr),
    .ram_we_o     (ram_we),
    .ram_be_o     (ram_be),
    .ram_wdata_o  (ram_wdata),
    .ram_rdata_i  (ram_rdata),
    .rd_count_o   (rd_count),
    .wr_count_o   (wr_count)
  );

  always #5 clk = ~clk;

  // Port-B RAM stand-in: byte-enabled writes, registered reads
  logic [31:0] ram_mem [0:(1<<(AW-2))-1];
  initial for (int i = 0; i < (1 << (AW - 2)); i++) ram_mem[i] = '0;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int k = 0; k < 4; k++)
          if (ram_be[k]) ram_mem[ram_addr[AW-1:2]][8*k +: 8] <= ram_wdata[8*k +: 8];
      end else begin
        ram_rdata <= ram_mem[ram_addr[AW-1:2]];
      end
    end
  end

  // Reference stall sequence: the spec's 16-bit Fibonacci LFSR, taps 16,14,13,11
  logic [15:0] lfsr_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic        we;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [int];
  int          m_rd, m_wr;
  int          errors = 0;
  int          checks = 0;
  int          hist[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic monitor_step();
    exp_t e;
    if (!rst_n) begin
      m_rd = 0;
      m_wr = 0;
      sb.delete();
    end else begin
      chk("rd_count", rd_count, 32'(m_rd));
      chk("wr_count", wr_count, 32'(m_wr));
      if (rvalid) begin
        if (sb.size() == 0) begin
          chk("spurious_rvalid", 32'(rvalid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rvalid_lag", 32'(cyc), 32'(e.cyc + 1));
          chk("err", 32'(err), 32'(e.err));
          chk("rdata", rdata, e.rdata);
          $display("resp cyc=%0d we=%0b err=%0b rdata=%h", cyc, e.we, err, rdata);
          if (!e.err) begin
            if (e.we) m_wr++;
            else      m_rd++;
          end
        end
      end else begin
        chk("idle_rdata", rdata, 32'h0);
        chk("idle_err", 32'(err), 32'd0);
      end
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    int idx = int'(a[AW-1:2]);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  task automatic do_txn(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d);
    int    waits;
    int    exp_s;
    logic  inr;
    exp_t  e;
    logic [31:0] cur;
    @(negedge clk);
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
    exp_s = stall_en ? (int'(lfsr_m[7:0]) % (STALL_MAX + 1)) : 0;
    inr   = (a < (32'd1 << AW));
    waits = 0;
    #1;
    while (!gnt && waits < 20) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!gnt) begin
      chk("gnt_timeout", 32'(gnt), 32'd1);
    end else begin
      chk("gnt_wait", 32'(waits), 32'(exp_s));
      chk("ram_en", 32'(ram_en), 32'(inr));
      if (stall_en && waits < 4) hist[waits]++;
      e.err = !inr; e.we = w; e.cyc = cyc; e.rdata = 32'h0;
      if (inr) begin
        cur = mem_read(a);
        if (w) begin
          for (int k = 0; k < 4; k++) if (b[k]) cur[8*k +: 8] = d[8*k +: 8];
          ref_mem[int'(a[AW-1:2])] = cur;
        end else begin
          e.rdata = cur;
        end
      end
      sb.push_back(e);
      $display("gnt cyc=%0d addr=%h we=%0b be=%h wdata=%h wait=%0d", cyc, a, w, b, d, waits);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req = 1'b0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_ram_en"}, 32'(ram_en), 32'd0);
    chk({tag, "_rd_count"}, rd_count, 32'd0);
    chk({tag, "_wr_count"}, wr_count, 32'd0);
    chk({tag, "_lfsr"}, 32'(dut.u_lfsr.lfsr_q), 32'h0000_ACE1);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] a;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // Power-on reset
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write then read, byte enables, out-of-range
    do_txn(32'h0000_0100, 1'b1, 4'hF, 32'hDEAD_BEEF);
    do_txn(32'h0000_0100, 1'b0, 4'hF, 32'h0);
    idle(2);
    chk("basic_wr_count", wr_count, 32'd1);
    chk("basic_rd_count", rd_count, 32'd1);
    do_txn(32'h0000_0200, 1'b1, 4'b0101, 32'h1122_3344);
    do_txn(32'h0000_0200, 1'b0, 4'hF, 32'h0);
    do_txn(32'h0001_0000, 1'b0, 4'hF, 32'h0);
    idle(2);

    // Pipelined: request held for 8 consecutive grants
    for (int i = 0; i < 8; i++)
      do_txn(32'h300 + 32'(4 * (i % 4)), 1'(i < 4), 4'(i + 9), $urandom);
    idle(3);

    // Random traffic with stalls enabled
    stall_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 9) == 0) a = 32'h0001_0000 | ($urandom & 32'h00FF_FFFC);
      else                           a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      do_txn(a, 1'($urandom), 4'($urandom), $urandom);
      n = $urandom_range(0, 2);
      if (n != 0) idle(n);
    end
    idle(3);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (hist[k] == 0) begin
        errors++;
        $display("FAIL stall_hist: stall length %0d seen %0d times, required >0", k, hist[k]);
      end
    end

    // Reset while the FSM is mid-stall
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((int'(lfsr_m[7:0]) % (STALL_MAX + 1)) < 2 && n < 100);
    req = 1'b1; addr = 32'h40; we = 1'b0; be = 4'hF;
    @(posedge clk);
    #1;
    chk("stall_before_reset_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stall_en = 1'b0;
    do_txn(32'h0000_0040, 1'b1, 4'hF, 32'hCAFE_F00D);
    do_txn(32'h0000_0040, 1'b0, 4'hF, 32'h0);
    idle(4);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
